// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry pipeline skid stage with flush and gated control
//
// Purpose:
//   Registered valid/ready pipeline stage. The main register drives the
//   outputs. The skid register catches the one entry that can arrive while
//   the downstream is stalled. Because in_ready is registered, there is no
//   combinational path from out_ready to in_ready.
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   rst        - synchronous active-high reset; has priority over everything
//   flush      - synchronous kill of all held entries; data registers are kept
//   in_valid   - upstream entry present
//   in_ready   - stage can accept an entry this cycle (registered)
//   in_ctrl    - upstream control field, CTRL_W bits
//   in_data    - upstream data field, DATA_W bits
//   out_valid  - downstream entry present
//   out_ready  - downstream accepts (low = stall)
//   out_ctrl   - downstream control field, zeroed when out_valid=0 and GATE_CTRL=1
//   out_data   - downstream data field
//   occupancy  - number of held entries (0..2)

module pipe_skid_stage #(
  parameter int CTRL_W    = 3,
  parameter int DATA_W    = 101,
  parameter bit GATE_CTRL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_ready_q;

  logic in_xfer;
  logic out_xfer;
  logic main_free;
  logic main_valid_nxt;
  logic skid_valid_nxt;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = main_valid && out_ready;

  // The main register may take a new entry when it is empty or is being
  // drained this cycle. The skid register only fills when main is stuck.
  // The case of a skid refill while skid is already full cannot arise,
  // because in_ready is low whenever skid is occupied.
  assign main_free = !main_valid || out_xfer;

  always_comb begin
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    if (main_free) begin
      main_valid_nxt = skid_valid || in_xfer;
      skid_valid_nxt = 1'b0;
    end else begin
      main_valid_nxt = 1'b1;
      skid_valid_nxt = skid_valid || in_xfer;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      // Only the valid bits drop. The payload registers keep their contents,
      // and the input offered in this cycle is discarded.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      // in_ready is the registered image of the next skid state.
      in_ready_q <= !skid_valid_nxt;
      if (main_free) begin
        if (skid_valid) begin
          main_ctrl <= skid_ctrl;
          main_data <= skid_data;
        end else if (in_xfer) begin
          main_ctrl <= in_ctrl;
          main_data <= in_data;
        end
      end else if (in_xfer) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = (GATE_CTRL && !main_valid) ? '0 : main_ctrl;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - self-checking bench for pipe_skid_stage against a queue model

module tb_pipe_skid_stage;

  localparam int CW = 3;
  localparam int DW = 101;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .GATE_CTRL(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int n_out  = 0;

  // Model: the stage is a FIFO of at most two accepted entries, in arrival order.
  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  ent_t q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Update the model on each rising edge from the inputs that were presented.
  always @(posedge clk) begin
    bit   in_x;
    bit   out_x;
    ent_t e;
    in_x  = in_valid && (q.size() < 2);
    out_x = (q.size() > 0) && out_ready;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (out_x) begin
        void'(q.pop_front());
        n_out++;
      end
      if (in_x) begin
        e.c = in_ctrl;
        e.d = in_data;
        q.push_back(e);
      end
    end
  end

  // Compare the DUT with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("occupancy", 128'(occupancy), 128'(q.size()));
      chk("in_ready",  128'(in_ready),  128'(q.size() < 2));
      if (q.size() > 0) begin
        chk("out_data", 128'(out_data), 128'(q[0].d));
        chk("out_ctrl", 128'(out_ctrl), 128'(q[0].c));
      end else begin
        chk("out_ctrl_gated", 128'(out_ctrl), 128'(0));
      end
    end
  end

  // Inputs are applied at a falling edge and take effect at the next rising
  // edge. The task returns at the following falling edge, where the new
  // outputs can be checked.
  task automatic step(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl, input logic r);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] r128;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_out_ctrl",  128'(out_ctrl),  128'(0));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));

    // Streaming: 1..4 appear one cycle later on consecutive cycles
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 3'd2, DW'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_data", 128'(out_data),  128'(i));
      chk("stream_occ",  128'(occupancy), 128'(1));
    end
    step(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b0);
    chk("stream_drain_occ", 128'(occupancy), 128'(0));

    // Stall and skid
    step(1'b1, 3'd1, DW'(32'hA), 1'b1, 1'b0, 1'b0);
    chk("skid_a_data", 128'(out_data), 128'(32'hA));
    step(1'b1, 3'd1, DW'(32'hB), 1'b0, 1'b0, 1'b0);
    chk("skid_occ2",     128'(occupancy), 128'(2));
    chk("skid_in_ready", 128'(in_ready),  128'(0));
    chk("skid_hold_a",   128'(out_data),  128'(32'hA));
    step(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b0);
    chk("skid_b_data",   128'(out_data),  128'(32'hB));
    chk("skid_ready_up", 128'(in_ready),  128'(1));
    step(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b0);
    chk("skid_empty", 128'(occupancy), 128'(0));

    // Flush with two entries held, ctrl=7, while 0xC is offered
    step(1'b1, 3'd7, DW'(32'h11), 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd7, DW'(32'h12), 1'b0, 1'b0, 1'b0);
    chk("flush_pre_occ", 128'(occupancy), 128'(2));
    step(1'b1, 3'd7, DW'(32'hC), 1'b0, 1'b1, 1'b0);
    chk("flush_valid",    128'(out_valid), 128'(0));
    chk("flush_ctrl",     128'(out_ctrl),  128'(0));
    chk("flush_occ",      128'(occupancy), 128'(0));
    chk("flush_in_ready", 128'(in_ready),  128'(1));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b0);
      chk("flush_no_c", 128'(out_valid), 128'(0));
    end

    // Reset has priority over flush and transfers
    step(1'b1, 3'd5, DW'(32'h21), 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd5, DW'(32'h22), 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd7, DW'(32'h23), 1'b1, 1'b1, 1'b1);
    chk("rstp_valid",    128'(out_valid), 128'(0));
    chk("rstp_data",     128'(out_data),  128'(0));
    chk("rstp_ctrl",     128'(out_ctrl),  128'(0));
    chk("rstp_occ",      128'(occupancy), 128'(0));
    chk("rstp_in_ready", 128'(in_ready),  128'(1));
    step(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b0);
    chk("rstp_after", 128'(out_valid), 128'(0));

    // Random traffic, with rare flushes and resets
    n_out = 0;
    for (int i = 0; i < 10000; i++) begin
      r128 = {$urandom, $urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 3) != 0), CW'($urandom), r128[DW-1:0],
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 127) == 0),
           1'($urandom_range(0, 1023) == 0));
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("random_drained", 128'(occupancy), 128'(0));
    if (n_out < 1000) begin
      checks++;
      errors++;
      $display("FAIL random_throughput: got %0d transfers expected at least 1000", n_out);
    end else begin
      checks++;
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 3, meaning the control field width (e.g. RegWrite plus ResultSrc).
REQ-002 The block SHALL have parameter DATA_W, default 101, meaning the data field width (ALU result 32 + read data 32 + rd 5 + PC+4 32).
REQ-003 The block SHALL have parameter GATE_CTRL, default 1, meaning out_ctrl is forced to 0 whenever out_valid is 0.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock (all state updates on its rising edge).
REQ-005 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port flush, input, 1 bit, a synchronous kill of all held entries.
REQ-007 The block SHALL have port in_valid, input, 1 bit, upstream entry present.
REQ-008 The block SHALL have port in_ready, output, 1 bit, the stage can accept an entry this cycle.
REQ-009 The block SHALL have port in_ctrl, input, CTRL_W bits, upstream control field.
REQ-010 The block SHALL have port in_data, input, DATA_W bits, upstream data field.
REQ-011 The block SHALL have port out_valid, output, 1 bit, downstream entry present.
REQ-012 The block SHALL have port out_ready, input, 1 bit, downstream accepts (low = stall).
REQ-013 The block SHALL have port out_ctrl, output, CTRL_W bits, downstream control field.
REQ-014 The block SHALL have port out_data, output, DATA_W bits, downstream data field.
REQ-015 The block SHALL have port occupancy, output, 2 bits, number of held entries (0..2).

Function
REQ-016 The block SHALL hold two entries: a main register (drives outputs) and a skid register, each with its own valid bit.
REQ-017 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL be registered and equal to NOT skid_valid; it SHALL not combinationally depend on out_ready.
REQ-019 out_valid, out_data and out_ctrl SHALL come directly from the main register, with out_ctrl gated to 0 when out_valid=0 and GATE_CTRL=1.
REQ-020 When the main register is empty or an output transfer occurs, the main register SHALL load from skid if skid_valid, else from the input if an input transfer occurs, else become empty.
REQ-021 When the main register is full, no output transfer occurs, and an input transfer occurs, the entry SHALL be captured into skid.
REQ-022 When the main register loads from skid, a simultaneous input transfer SHALL not be possible (in_ready=0 while skid full).
REQ-023 Entries SHALL leave in strict acceptance order; no entry SHALL be dropped or duplicated absent flush/rst.
REQ-024 Latency SHALL be one cycle from input transfer to out_valid when the stage is empty, with full throughput (one entry per cycle) while out_ready=1.
REQ-025 Simultaneous input and output transfer with main full and skid empty SHALL replace main with the new entry; occupancy stays 1.
REQ-026 occupancy SHALL equal main_valid + skid_valid; a value of 3 SHALL never occur.
REQ-027 flush=1 SHALL, at the next edge, clear main_valid and skid_valid; any input transfer in the flush cycle SHALL be discarded; in_ready=1 the following cycle.
REQ-028 Flush SHALL leave data registers unchanged; only valid bits and (via gating) out_ctrl SHALL reflect the bubble.
REQ-029 Widths SHALL pass through bit-exact; the block SHALL perform no arithmetic on ctrl or data.

Reset
REQ-030 rst=1 at a rising edge SHALL clear both valid bits and zero both data and ctrl registers, with priority over flush and all transfers.
REQ-031 After reset, outputs SHALL be: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
REQ-032 Reset asserted mid-operation with two entries held SHALL discard both entries, and no output transfer SHALL occur after that edge.

Verification
REQ-033 Streaming: out_ready=1, in_valid=1 for 4 cycles with data 0x1..0x4 -> out_data 0x1..0x4 on consecutive cycles, one cycle behind, occupancy=1 throughout.
REQ-034 Stall/skid: accept 0xA, then out_ready=0 while 0xB is offered -> occupancy=2, in_ready=0; raise out_ready -> 0xA then 0xB out in order, in_ready=1 one cycle after skid drains.
REQ-035 Flush: occupancy=2 with ctrl=3'b111, assert flush while in_valid=1 carrying 0xC -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0xC never appears.
REQ-036 Reset priority: rst=1 and flush=1 with in_valid=1 in the same cycle -> all outputs zero, in_ready=1 next cycle.
REQ-037 Random: random in_valid and out_ready over 10k cycles -> scoreboard order match, no loss or duplication, occupancy never 3, and out_ctrl=0 whenever out_valid=0.
